sync_fifo_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/sync_fifo_param.sv | 124 ++++++++++++
 tb/tb_sync_fifo_param.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Exports default sizes, the read-mode encoding and clog2.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: synchronous write, combinational read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = 1 << DEF_ADDR_WIDTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with thresholds, flush and FWFT option.
// Ports: clk/reset/clear, push/pop, data, flags, error pulses, count.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = MODE_REG
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  clear_in,
  input  logic                  wt_en_in,
  input  logic                  rd_en_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  almost_full_out,
  output logic                  almost_empty_out,
  output logic                  push_on_full_error_out,
  output logic                  pop_on_empty_error_out,
  output logic [ADDR_WIDTH:0]   count_out
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] AF_TH   = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_TH   = AE_LEVEL[AW:0];
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_cfg
    $error("sync_fifo_param: need AE_LEVEL < AF_LEVEL <= depth");
  end

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_err_q, push_err_d;
  logic        pop_err_q, pop_err_d;
  logic        full, empty;
  logic        push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push_ok = wt_en_in & ~full & ~clear_in;
  assign pop_ok  = rd_en_in & ~empty & ~clear_in;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push_err_d = 1'b0;
    pop_err_d  = 1'b0;
    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      push_err_d = wt_en_in & full;
      pop_err_d  = rd_en_in & empty;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      push_err_q <= push_err_d;
      pop_err_q  <= pop_err_d;
    end
  end

  sync_fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_in),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head word is presented directly; forced to 0 while empty
    // so unwritten memory never leaks out as X.
    assign data_out = empty ? '0 : rdata;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (clear_in)    dout_d = '0;
      else if (pop_ok) dout_d = rdata;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) dout_q <= '0;
      else           dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

  assign count_out              = wr_ptr_q - rd_ptr_q;
  assign full_out               = full;
  assign empty_out              = empty;
  assign almost_full_out        = (count_out >= AF_TH);
  assign almost_empty_out       = (count_out <= AE_TH);
  assign push_on_full_error_out = push_err_q;
  assign pop_on_empty_error_out = pop_err_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered and FWFT instances on shared
// stimulus, checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] r_dout, f_dout;
  logic       r_full, r_empty, r_af, r_ae, r_perr, r_eerr;
  logic       f_full, f_empty, f_af, f_ae, f_perr, f_eerr;
  logic [4:0] r_cnt, f_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout = '0;
  logic       exp_perr = 1'b0;
  logic       exp_eerr = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) u_reg (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clr),
    .wt_en_in(we), .rd_en_in(re), .data_in(din),
    .data_out(r_dout), .full_out(r_full), .empty_out(r_empty),
    .almost_full_out(r_af), .almost_empty_out(r_ae),
    .push_on_full_error_out(r_perr),
    .pop_on_empty_error_out(r_eerr), .count_out(r_cnt)
  );

  sync_fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) u_fwft (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clr),
    .wt_en_in(we), .rd_en_in(re), .data_in(din),
    .data_out(f_dout), .full_out(f_full), .empty_out(f_empty),
    .almost_full_out(f_af), .almost_empty_out(f_ae),
    .push_on_full_error_out(f_perr),
    .pop_on_empty_error_out(f_eerr), .count_out(f_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("r_count", r_cnt, n);
    chk("r_empty", r_empty, n == 0);
    chk("r_full", r_full, n == DEPTH);
    chk("r_af", r_af, n >= AF);
    chk("r_ae", r_ae, n <= AE);
    chk("r_perr", r_perr, exp_perr);
    chk("r_eerr", r_eerr, exp_eerr);
    chk("r_dout", r_dout, exp_dout);
    chk("f_count", f_cnt, n);
    chk("f_empty", f_empty, n == 0);
    chk("f_full", f_full, n == DEPTH);
    chk("f_af", f_af, n >= AF);
    chk("f_ae", f_ae, n <= AE);
    chk("f_perr", f_perr, exp_perr);
    chk("f_eerr", f_eerr, exp_eerr);
    if (n > 0) chk("f_dout", f_dout, q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_perr = 1'b0;
    exp_eerr = 1'b0;
  endtask

  // One clock: drive at negedge, update model at posedge, check at
  // the following negedge.
  task automatic step(input bit w, input bit r, input bit c,
                      input logic [7:0] d);
    bit was_full, was_empty;
    we = w; re = r; clr = c; din = d;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      model_reset();
    end else begin
      exp_perr = w && was_full;
      exp_eerr = r && was_empty;
      if (r && !was_empty) exp_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0; clr = 1'b0;
    check_all();
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic pop();
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    for (int i = 0; i < 3; i++) push(8'($urandom));

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow attempt, then idle to see the pulse drop.
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hAA);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Drain in order, then underflow attempt and idle.
    for (int i = 0; i < 17; i++) pop();
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Steady state at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) push(8'($urandom));
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b0, 8'($urandom));

    // Push+pop while full: push rejected, pop accepted.
    for (int i = 0; i < 11; i++) push(8'($urandom));
    step(1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Drain, then single write seen by the FWFT port.
    while (q.size() > 0) pop();
    push(8'h3C);
    pop();

    // Flush at count 9 with push and pop requested.
    for (int i = 0; i < 9; i++) push(8'($urandom));
    step(1'b1, 1'b1, 1'b1, 8'h55);
    push(8'hC3);
    pop();

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 49) == 0, 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
